// File: rtl/aibcr3_rxword_align_if.sv
// Bus bundle between the RX capture/adapter side and the word aligner.
interface aibcr3_rxword_align_if #(
    parameter int unsigned WIDTH = 20
);
    localparam int unsigned OFF_W = $clog2(WIDTH);

    logic             ien;
    logic             idat0;
    logic             idat1;
    logic [WIDTH-1:0] imark;
    logic [WIDTH-1:0] imask;
    logic             iclr_err;
    logic [WIDTH-1:0] odata;
    logic             odata_vld;
    logic             olock;
    logic [1:0]       ostate;
    logic             oslip;
    logic [OFF_W-1:0] ooffset;
    logic [7:0]       oerr_cnt;

    modport master (
        output ien, idat0, idat1, imark, imask, iclr_err,
        input  odata, odata_vld, olock, ostate, oslip, ooffset, oerr_cnt
    );

    modport slave (
        input  ien, idat0, idat1, imark, imask, iclr_err,
        output odata, odata_vld, olock, ostate, oslip, ooffset, oerr_cnt
    );
endinterface

// File: rtl/aibcr3_rxword_align.sv
// Deserialises the AIB RX DDR bit pair into WIDTH-bit words and locks the
// word boundary onto a masked marker with a HUNT/CHECK/LOCK state machine.
module aibcr3_rxword_align #(
    parameter int unsigned WIDTH    = 20,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input logic                   iclkin_dist,
    input logic                   irst,
    aibcr3_rxword_align_if.slave  bus
);
    localparam int unsigned SR_W   = 2 * WIDTH;
    localparam int unsigned OFF_W  = $clog2(WIDTH);
    localparam int unsigned BEATS  = WIDTH / 2;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    logic [SR_W-1:0]   r_sr;
    logic [BEAT_W-1:0] r_beat;
    state_t            r_state;
    logic [GOOD_W-1:0] r_good;
    logic [BAD_W-1:0]  r_bad;
    logic [OFF_W-1:0]  r_offset;
    logic [7:0]        r_err;
    logic [WIDTH-1:0]  r_odata;
    logic              r_vld;
    logic              r_slip;
    logic              r_lock;

    logic [WIDTH-1:0]  w_window;
    logic              w_match;
    logic              w_strobe;
    logic [OFF_W-1:0]  w_offset_inc;
    logic [GOOD_W-1:0] w_good_inc;
    logic [BAD_W-1:0]  w_bad_inc;
    state_t            w_state_nxt;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [BAD_W-1:0]  w_bad_nxt;
    logic [OFF_W-1:0]  w_offset_nxt;
    logic              w_slip_nxt;
    logic              w_err_inc;

    // Window at the current offset; higher offsets look at older bits.
    assign w_window     = WIDTH'(r_sr >> r_offset);
    assign w_match      = ((w_window ^ bus.imark) & bus.imask) == '0;
    assign w_strobe     = bus.ien && (r_beat == BEAT_W'(BEATS - 1));
    assign w_offset_inc = (r_offset == OFF_W'(WIDTH - 1)) ? '0 : r_offset + OFF_W'(1);
    assign w_good_inc   = r_good + GOOD_W'(1);
    assign w_bad_inc    = r_bad + BAD_W'(1);

    // Pair shifter runs regardless of enable so history is always current.
    always_ff @(posedge iclkin_dist or posedge irst) begin
        if (irst) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[SR_W-3:0], bus.idat0, bus.idat1};
        end
    end

    always_ff @(posedge iclkin_dist or posedge irst) begin
        if (irst) begin
            r_beat <= '0;
        end else if (!bus.ien || w_strobe) begin
            r_beat <= '0;
        end else begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    always_ff @(posedge iclkin_dist or posedge irst) begin
        if (irst) begin
            r_state  <= ST_HUNT;
            r_good   <= '0;
            r_bad    <= '0;
            r_offset <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_bad    <= w_bad_nxt;
            r_offset <= w_offset_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_bad_nxt    = r_bad;
        w_offset_nxt = r_offset;
        w_slip_nxt   = 1'b0;
        w_err_inc    = 1'b0;
        if (!bus.ien) begin
            w_state_nxt  = ST_HUNT;
            w_good_nxt   = '0;
            w_bad_nxt    = '0;
            w_offset_nxt = '0;
        end else if (w_strobe) begin
            unique case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        w_good_nxt  = GOOD_W'(1);
                        w_bad_nxt   = '0;
                        w_state_nxt = (LOCK_CNT == 1) ? ST_LOCK : ST_CHECK;
                    end else begin
                        w_offset_nxt = w_offset_inc;
                        w_slip_nxt   = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                            w_state_nxt = ST_LOCK;
                            w_bad_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt  = ST_HUNT;
                        w_good_nxt   = '0;
                        w_offset_nxt = w_offset_inc;
                        w_slip_nxt   = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (w_match) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_inc = 1'b1;
                        w_bad_nxt = w_bad_inc;
                        // Losing lock keeps the offset; the hunt restarts from it.
                        if (w_bad_inc == BAD_W'(LOSS_CNT)) begin
                            w_state_nxt = ST_HUNT;
                            w_good_nxt  = '0;
                            w_bad_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iclkin_dist or posedge irst) begin
        if (irst) begin
            r_odata <= '0;
            r_vld   <= 1'b0;
            r_slip  <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_vld  <= w_strobe;
            r_slip <= w_slip_nxt;
            r_lock <= (w_state_nxt == ST_LOCK);
            if (w_strobe) begin
                r_odata <= w_window;
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge iclkin_dist or posedge irst) begin
        if (irst) begin
            r_err <= '0;
        end else if (bus.iclr_err) begin
            r_err <= '0;
        end else if (w_err_inc && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign bus.odata     = r_odata;
    assign bus.odata_vld = r_vld;
    assign bus.olock     = r_lock;
    assign bus.ostate    = r_state;
    assign bus.oslip     = r_slip;
    assign bus.ooffset   = r_offset;
    assign bus.oerr_cnt  = r_err;

endmodule

// File: tb/tb_aibcr3_rxword_align.sv
// Randomised and directed bench for aibcr3_rxword_align against a bit-history model.
module tb_aibcr3_rxword_align;
    localparam int unsigned W        = 20;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned LOSS_CNT = 3;
    localparam int unsigned OW       = $clog2(W);
    localparam int unsigned VW       = W + OW + 13;

    logic clk = 1'b0;
    logic irst;
    int   checks = 0;
    int   failures = 0;
    bit   rand_fill = 1'b0;
    bit   txq[$];

    aibcr3_rxword_align_if #(.WIDTH(W)) dif ();

    aibcr3_rxword_align #(.WIDTH(W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .iclkin_dist (clk),
        .irst        (irst),
        .bus         (dif)
    );

    always #5 clk = ~clk;

    // Reference model: full bit history, window picked by index arithmetic.
    bit   hist[$];
    int   m_state = 0, m_beat = 0, m_off = 0, m_good = 0, m_bad = 0, m_err = 0;
    logic [W-1:0] m_odata = '0;
    bit   m_vld = 0, m_slip = 0;

    function automatic logic [W-1:0] win(int k);
        logic [W-1:0] w = '0;
        for (int i = 0; i < int'(W); i++) begin
            int idx = hist.size() - 1 - k - i;
            w[i] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return w;
    endfunction

    always @(posedge clk or posedge irst) begin : mdl
        logic [W-1:0] w;
        bit mt, strobe;
        if (irst) begin
            m_state = 0; m_beat = 0; m_off = 0; m_good = 0; m_bad = 0; m_err = 0;
            m_odata = '0; m_vld = 0; m_slip = 0;
            hist.delete();
        end else begin
            w      = win(m_off);
            mt     = (((w ^ dif.imark) & dif.imask) == '0);
            strobe = dif.ien && (m_beat == int'(W / 2) - 1);
            m_vld  = 0;
            m_slip = 0;
            if (!dif.ien) begin
                m_state = 0; m_beat = 0; m_off = 0; m_good = 0; m_bad = 0;
            end else begin
                m_beat = (m_beat + 1) % int'(W / 2);
                if (strobe) begin
                    m_odata = w;
                    m_vld   = 1;
                    if (m_state == 0) begin
                        if (mt) begin
                            m_good = 1; m_bad = 0;
                            m_state = (LOCK_CNT == 1) ? 2 : 1;
                        end else begin
                            m_off = (m_off + 1) % int'(W); m_slip = 1;
                        end
                    end else if (m_state == 1) begin
                        if (mt) begin
                            m_good++;
                            if (m_good >= int'(LOCK_CNT)) begin m_state = 2; m_bad = 0; end
                        end else begin
                            m_state = 0; m_good = 0; m_off = (m_off + 1) % int'(W); m_slip = 1;
                        end
                    end else begin
                        if (mt) m_bad = 0;
                        else begin
                            m_bad++;
                            if (m_err < 255) m_err++;
                            if (m_bad >= int'(LOSS_CNT)) begin m_state = 0; m_good = 0; m_bad = 0; end
                        end
                    end
                end
            end
            if (dif.iclr_err) m_err = 0;
            hist.push_back(dif.idat0);
            hist.push_back(dif.idat1);
            while (hist.size() > 2 * W) void'(hist.pop_front());
        end
    end

    function automatic logic [VW-1:0] dut_vec();
        return {dif.odata, dif.odata_vld, dif.olock, dif.ostate, dif.oslip, dif.ooffset, dif.oerr_cnt};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_odata, m_vld, (m_state == 2), 2'(m_state), m_slip, OW'(m_off), 8'(m_err)};
    endfunction

    function automatic logic [W-1:0] mkword(int c, bit bad);
        logic [7:0] mk = bad ? 8'h25 : 8'hA5;
        return {mk, 12'(c)};
    endfunction

    task automatic tick();
        dif.idat0 = (txq.size() > 0) ? txq.pop_front() : (rand_fill ? 1'($urandom) : 1'b0);
        dif.idat1 = (txq.size() > 0) ? txq.pop_front() : (rand_fill ? 1'($urandom) : 1'b0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(logic [W-1:0] w);
        for (int i = int'(W) - 1; i >= 0; i--) txq.push_back(w[i]);
    endtask

    task automatic load_marker_stream(int delay, int nwords, logic [31:0] bad);
        txq.delete();
        for (int i = 0; i < delay; i++) txq.push_back(1'b0);
        for (int j = 0; j < nwords; j++) push_word(mkword(j, bad[j]));
    endtask

    // First pair is sampled with ien low so word boundaries land on strobes.
    task automatic arm();
        dif.ien = 1'b0;
        tick();
        dif.ien = 1'b1;
    endtask

    task automatic clear_err();
        dif.iclr_err = 1'b1;
        tick();
        dif.iclr_err = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL reset_hold got=%h exp=0", dut_vec());
        end
        irst = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL reset_idle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
            checks++;
            if (dif.odata_vld !== 1'b0) begin
                failures++; $display("FAIL reset_idle_vld cycle=%0d got=%b exp=0", n, dif.odata_vld);
            end
        end
    endtask

    task automatic test_aligned();
        int nv = 0, slips = 0;
        dif.imark = 20'hA5000; dif.imask = 20'hFF000;
        load_marker_stream(0, 12, 32'h0);
        arm();
        for (int n = 1; n <= 100; n++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL aligned_cycle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
            if (dif.oslip) slips++;
            if (dif.odata_vld) begin
                nv++;
                checks++;
                if (dif.odata !== mkword(nv - 1, 0) || n != 10 * nv) begin
                    failures++; $display("FAIL aligned_word n=%0d got=%h exp=%h at cycle %0d", nv, dif.odata, mkword(nv - 1, 0), n);
                end
                if (nv == 3 || nv == 4) begin
                    checks++;
                    if (dif.olock !== (nv == 4)) begin
                        failures++; $display("FAIL aligned_lock strobe=%0d got=%b exp=%b", nv, dif.olock, nv == 4);
                    end
                end
            end
        end
        checks++;
        if (slips != 0 || nv != 10) begin
            failures++; $display("FAIL aligned_totals slips=%0d words=%0d exp slips=0 words=10", slips, nv);
        end
    endtask

    task automatic test_skewed();
        int nv = 0, slips = 0;
        dif.imark = 20'hA5000; dif.imask = 20'hFF000;
        load_marker_stream(13, 16, 32'h0);
        arm();
        for (int n = 1; n <= 150; n++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL skewed_cycle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
            if (dif.oslip) slips++;
            if (dif.odata_vld) begin
                nv++;
                if (nv >= 8) begin
                    checks++;
                    if (dif.odata !== mkword(nv - 2, 0)) begin
                        failures++; $display("FAIL skewed_word strobe=%0d got=%h exp=%h", nv, dif.odata, mkword(nv - 2, 0));
                    end
                end
            end
            if (n == 100 || n == 110) begin
                checks++;
                if (dif.olock !== (n == 110)) begin
                    failures++; $display("FAIL skewed_lock cycle=%0d got=%b exp=%b", n, dif.olock, n == 110);
                end
            end
        end
        checks++;
        if (slips != 7 || dif.ooffset !== OW'(7) || dif.olock !== 1'b1) begin
            failures++; $display("FAIL skewed_final slips=%0d off=%0d lock=%b exp 7/7/1", slips, dif.ooffset, dif.olock);
        end
    endtask

    task automatic test_check_fail();
        int slips = 0;
        dif.imark = 20'hA5000; dif.imask = 20'hFF000;
        load_marker_stream(0, 6, 32'h4);
        arm();
        for (int n = 1; n <= 30; n++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL checkfail_cycle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
            if (dif.oslip) slips++;
            if (n == 20) begin
                checks++;
                if (dif.ostate !== 2'd1) begin
                    failures++; $display("FAIL checkfail_state2 got=%0d exp=1", dif.ostate);
                end
            end
        end
        checks++;
        if (dif.ostate !== 2'd0 || dif.oslip !== 1'b1 || dif.ooffset !== OW'(1) || slips != 1) begin
            failures++; $display("FAIL checkfail_drop state=%0d slip=%b off=%0d slips=%0d exp 0/1/1/1",
                                 dif.ostate, dif.oslip, dif.ooffset, slips);
        end
    endtask

    task automatic test_loss_of_lock();
        dif.imark = 20'hA5000; dif.imask = 20'hFF000;
        clear_err();
        load_marker_stream(0, 17, 32'h43B0);
        arm();
        for (int n = 1; n <= 160; n++) begin
            dif.iclr_err = (n == 150);
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL loss_cycle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
            if (n == 90) begin
                checks++;
                if (dif.olock !== 1'b1 || dif.oerr_cnt !== 8'd4) begin
                    failures++; $display("FAIL loss_two_bad lock=%b err=%0d exp 1/4", dif.olock, dif.oerr_cnt);
                end
            end
            if (n == 100) begin
                checks++;
                if (dif.oerr_cnt !== 8'd5 || dif.olock !== 1'b0 || dif.ostate !== 2'd0 ||
                    dif.oslip !== 1'b0 || dif.ooffset !== '0) begin
                    failures++; $display("FAIL loss_drop err=%0d lock=%b state=%0d slip=%b off=%0d exp 5/0/0/0/0",
                                         dif.oerr_cnt, dif.olock, dif.ostate, dif.oslip, dif.ooffset);
                end
            end
            if (n == 140) begin
                checks++;
                if (dif.olock !== 1'b1) begin
                    failures++; $display("FAIL loss_relock got=%b exp=1", dif.olock);
                end
            end
            if (n == 150) begin
                checks++;
                if (dif.oerr_cnt !== 8'd0) begin
                    failures++; $display("FAIL loss_clear_wins got=%0d exp=0", dif.oerr_cnt);
                end
            end
        end
        dif.iclr_err = 1'b0;
    endtask

    task automatic test_reset_midlock();
        dif.imark = 20'hA5000; dif.imask = 20'hFF000;
        clear_err();
        load_marker_stream(0, 12, 32'h5B0);
        arm();
        for (int n = 1; n <= 110; n++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL midlock_cycle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (dif.oerr_cnt !== 8'd5 || dif.olock !== 1'b1) begin
            failures++; $display("FAIL midlock_pre err=%0d lock=%b exp 5/1", dif.oerr_cnt, dif.olock);
        end
        #2 irst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL midlock_async got=%h exp=0", dut_vec());
        end
        @(posedge clk);
        @(negedge clk);
        dif.ien = 1'b0;
        test_reset();
    endtask

    task automatic test_ien_drop();
        dif.imark = 20'hA5000; dif.imask = 20'hFF000;
        clear_err();
        load_marker_stream(13, 16, 32'hC00);
        arm();
        for (int n = 1; n <= 140; n++) begin
            if (n == 135) dif.ien = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++; $display("FAIL iendrop_cycle cycle=%0d got=%h exp=%h", n, dut_vec(), mdl_vec());
            end
            if (n == 134) begin
                checks++;
                if (dif.olock !== 1'b1 || dif.ooffset !== OW'(7) || dif.oerr_cnt !== 8'd2) begin
                    failures++; $display("FAIL iendrop_pre lock=%b off=%0d err=%0d exp 1/7/2", dif.olock, dif.ooffset, dif.oerr_cnt);
                end
            end
            if (n == 135) begin
                checks++;
                if (dif.ostate !== 2'd0 || dif.olock !== 1'b0 || dif.ooffset !== '0 || dif.oerr_cnt !== 8'd2) begin
                    failures++; $display("FAIL iendrop_clear state=%0d lock=%b off=%0d err=%0d exp 0/0/0/2",
                                         dif.ostate, dif.olock, dif.ooffset, dif.oerr_cnt);
                end
            end
        end
        test_aligned();
    endtask

    task automatic test_random();
        rand_fill = 1'b1;
        for (int r = 0; r < 4; r++) begin
            logic [W-1:0] mark, mask, lsb, w;
            mark = W'($urandom);
            mask = (r == 0) ? '0 : W'($urandom);
            lsb  = mask & (~mask + W'(1));
            dif.imark = mark; dif.imask = mask;
            txq.delete();
            for (int i = 0; i < int'($urandom_range(0, W - 1)); i++) txq.push_back(1'($urandom));
            for (int j = 0; j < 45; j++) begin
                w = (W'($urandom) & ~mask) | (mark & mask);
                if ($urandom_range(0, 4) == 0) w = w ^ lsb;
                push_word(w);
            end
            arm();
            for (int n = 1; n <= 400; n++) begin
                dif.iclr_err = ($urandom_range(0, 49) == 0);
                dif.ien      = ($urandom_range(0, 99) != 0);
                tick();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    failures++; $display("FAIL random_cycle round=%0d cycle=%0d got=%h exp=%h", r, n, dut_vec(), mdl_vec());
                end
            end
        end
        dif.iclr_err = 1'b0;
        rand_fill = 1'b0;
    endtask

    initial begin
        dif.ien = 1'b0; dif.idat0 = 1'b0; dif.idat1 = 1'b0;
        dif.imark = '0; dif.imask = '0; dif.iclr_err = 1'b0;
        irst = 1'b0;
        #1 irst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_aligned();
        test_skewed();
        test_check_fail();
        test_loss_of_lock();
        test_reset_midlock();
        test_ien_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
